// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the 7-segment scan controller.
//   SEG_BLANK  : segment pattern with every (active-low) segment off
//   AN_OFF     : anode vector with every (active-low) anode off, MAX_DIGITS wide
//   MAX_DIGITS : largest digit count the controller supports
//   nib_sel_t  : digit index / nibble-select type
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int              MAX_DIGITS = 8;
    localparam logic [6:0]      SEG_BLANK  = 7'b1111111;
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    typedef logic [$clog2(MAX_DIGITS)-1:0] nib_sel_t;

endpackage

// File: rtl/seg_scan_mux_if.sv
// -----------------------------------------------------------------------------
// seg_scan_mux_if
// Signal bundle between the scan controller, its data source, the external
// hex-to-segment decoder and the display pins.
//   value_in   : 32-bit value to display (source -> controller)
//   load       : one-cycle capture strobe for value_in
//   lz_en      : leading-zero suppression enable
//   digit_hex  : nibble currently selected (controller -> decoder)
//   seg_in     : registered decoder pattern, active-low (decoder -> controller)
//   seg_out    : segment pins, active-low
//   an         : anode pins, active-low, one per digit
//   frame_done : one-cycle pulse when the scan wraps back to digit 0
// Modport slave is the controller side; master is everything around it.
// -----------------------------------------------------------------------------
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 8
);

    logic [31:0]           value_in;
    logic                  load;
    logic                  lz_en;
    logic [3:0]            digit_hex;
    logic [6:0]            seg_in;
    logic [6:0]            seg_out;
    logic [NUM_DIGITS-1:0] an;
    logic                  frame_done;

    modport slave (
        input  value_in,
        input  load,
        input  lz_en,
        input  seg_in,
        output digit_hex,
        output seg_out,
        output an,
        output frame_done
    );

    modport master (
        output value_in,
        output load,
        output lz_en,
        output seg_in,
        input  digit_hex,
        input  seg_out,
        input  an,
        input  frame_done
    );

endinterface

// File: rtl/seg_lz_mask.sv
// -----------------------------------------------------------------------------
// seg_lz_mask
// Combinational leading-zero blank mask.
//   disp  in  32         : displayed value
//   lz_en in  1          : suppression enable
//   blank out NUM_DIGITS : bit i set when digit i must stay dark
// Digit i (i > 0) is dark when every nibble from i upward is zero. Digit 0
// is never dark, so a value of zero still shows a single "0". Only the
// scanned nibbles take part in the evaluation.
// -----------------------------------------------------------------------------
module seg_lz_mask
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic [4*MAX_DIGITS-1:0] disp,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   blank
);

    logic [NUM_DIGITS-1:0] zero_above;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
        assign zero_above[gi] = (disp[4*NUM_DIGITS-1:4*gi] == '0);
    end

    // Bit 0 is masked off so the least significant digit always lights.
    assign blank = lz_en ? (zero_above & ~NUM_DIGITS'(1)) : '0;

endmodule

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexed scan controller for a common-anode 7-segment display.
//   slowClk in  1  scan clock, all state on the rising edge
//   reset   in  1  synchronous, active-high
//   bus     slave modport of seg_scan_mux_if (value/load/lz_en in, decoder
//           handshake digit_hex/seg_in, pins seg_out/an, frame_done pulse)
// Each digit owns a slot of REFRESH_DIV cycles. The first cycle of a slot
// keeps all anodes dark while the external decoder (one cycle latency)
// catches up with the new nibble; the anode then lights for the rest of the
// slot. New values are staged in a pending register and only copied to the
// display register at the frame wrap, so a frame never mixes two values.
// -----------------------------------------------------------------------------
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 4096
) (
    input  logic          slowClk,
    input  logic          reset,
    seg_scan_mux_if.slave bus
);

    localparam int                    CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam nib_sel_t              IDX_LAST = nib_sel_t'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_OFF[NUM_DIGITS-1:0];

    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    nib_sel_t              idx_reg, idx_next;
    logic [31:0]           disp_reg, disp_next;
    logic [31:0]           pend_reg, pend_next;
    logic                  pend_v_reg, pend_v_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic                  frame_done_reg, frame_done_next;

    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] an_slot;

    seg_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .disp  (disp_reg),
        .lz_en (bus.lz_en),
        .blank (blank)
    );

    // Anode pattern for the digit currently addressed, dark if suppressed.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
        assign an_slot[gi] = !((idx_reg == nib_sel_t'(gi)) && !blank[gi]);
    end

    always_comb begin
        slot_end        = (cnt_reg == CNT_LAST);
        frame_end       = slot_end && (idx_reg == IDX_LAST);

        cnt_next        = slot_end ? '0 : cnt_reg + 1'b1;
        idx_next        = idx_reg;
        disp_next       = disp_reg;
        pend_next       = pend_reg;
        pend_v_next     = pend_v_reg;
        an_next         = an_reg;
        frame_done_next = frame_end;

        if (slot_end) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end

        // A load landing exactly on the wrap bypasses the pending stage.
        if (frame_end) begin
            if (bus.load) begin
                disp_next   = bus.value_in;
                pend_v_next = 1'b0;
            end else if (pend_v_reg) begin
                disp_next   = pend_reg;
                pend_v_next = 1'b0;
            end
        end else if (bus.load) begin
            pend_next   = bus.value_in;
            pend_v_next = 1'b1;
        end

        // Dark for the first cycle of every slot; the anode pattern is
        // latched once on that cycle and held, so lz_en changes only take
        // effect at the next slot.
        if (slot_end) begin
            an_next = AN_IDLE;
        end else if (cnt_reg == '0) begin
            an_next = an_slot;
        end
    end

    always_ff @(posedge slowClk) begin
        if (reset) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            disp_reg       <= '0;
            pend_reg       <= '0;
            pend_v_reg     <= 1'b0;
            an_reg         <= AN_IDLE;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            disp_reg       <= disp_next;
            pend_reg       <= pend_next;
            pend_v_reg     <= pend_v_next;
            an_reg         <= an_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign bus.digit_hex  = disp_reg[{idx_reg, 2'b00} +: 4];
    assign bus.seg_out    = (an_reg == AN_IDLE) ? SEG_BLANK : bus.seg_in;
    assign bus.an         = an_reg;
    assign bus.frame_done = frame_done_reg;

endmodule
